// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage issue buffer: ALU op codes,
// RV32I major opcodes and the buffered entry format.
package ex_pkg;

  localparam logic [3:0] AND   = 4'b0000;
  localparam logic [3:0] OR    = 4'b0001;
  localparam logic [3:0] SUM   = 4'b0010;
  localparam logic [3:0] EQUAL = 4'b0011;
  localparam logic [3:0] SLL   = 4'b0100;
  localparam logic [3:0] SRL   = 4'b0101;
  localparam logic [3:0] SRA   = 4'b0111;
  localparam logic [3:0] XOR   = 4'b1000;
  localparam logic [3:0] NOR   = 4'b1001;
  localparam logic [3:0] SUB   = 4'b1010;
  localparam logic [3:0] GE    = 4'b1100;
  localparam logic [3:0] GEU   = 4'b1101;
  localparam logic [3:0] SLT   = 4'b1110;
  localparam logic [3:0] SLTU  = 4'b1111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        branch;
    logic        take_on_zero;
    logic        illegal;
  } issue_entry_t;

endpackage

// File: rtl/ex_issue_if.sv
// Decode-to-ALU handshake bundle; slave is the issue buffer, master the driver/consumer side.
interface ex_issue_if;

  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_alu_rs1;
  logic [31:0] out_alu_rs2;
  logic        out_branch;
  logic        out_take_on_zero;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7_5, in_pc, in_rs1, in_rs2, in_imm,
    output in_ready,
    output out_valid, out_alu_op, out_alu_rs1, out_alu_rs2, out_branch,
           out_take_on_zero, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7_5, in_pc, in_rs1, in_rs2, in_imm,
    input  in_ready,
    input  out_valid, out_alu_op, out_alu_rs1, out_alu_rs2, out_branch,
           out_take_on_zero, out_illegal,
    output out_ready
  );

endinterface

// File: rtl/ex_issue_decode.sv
// Combinational RV32I field decode into ALU operands, op code and branch condition.
module ex_issue_decode
  import ex_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1,
  input  logic [31:0]  rs2,
  input  logic [31:0]  imm,
  output issue_entry_t entry
);

  logic [3:0] arith_op;

  // Bit 30 only means SUB for register-register ops; for ADDI it is an immediate bit.
  always_comb begin
    arith_op = SUM;
    case (funct3)
      3'b000:  arith_op = (opcode == OPC_OP && funct7_5) ? SUB : SUM;
      3'b001:  arith_op = SLL;
      3'b010:  arith_op = SLT;
      3'b011:  arith_op = SLTU;
      3'b100:  arith_op = XOR;
      3'b101:  arith_op = funct7_5 ? SRA : SRL;
      3'b110:  arith_op = OR;
      default: arith_op = AND;
    endcase
  end

  always_comb begin
    entry = '0;
    case (opcode)
      OPC_LUI: begin
        entry.op = SUM;
        entry.b  = imm;
      end
      OPC_AUIPC: begin
        entry.op = SUM;
        entry.a  = pc;
        entry.b  = imm;
      end
      OPC_JAL, OPC_JALR: begin
        entry.op = SUM;
        entry.a  = pc;
        entry.b  = 32'd4;
      end
      OPC_LOAD, OPC_STORE: begin
        entry.op = SUM;
        entry.a  = rs1;
        entry.b  = imm;
      end
      OPC_OP_IMM: begin
        entry.op = arith_op;
        entry.a  = rs1;
        entry.b  = imm;
      end
      OPC_OP: begin
        entry.op = arith_op;
        entry.a  = rs1;
        entry.b  = rs2;
      end
      OPC_BRANCH: begin
        entry.a      = rs1;
        entry.b      = rs2;
        entry.branch = 1'b1;
        case (funct3)
          3'b000: begin
            entry.op           = SUB;
            entry.take_on_zero = 1'b1;
          end
          3'b001:  entry.op = SUB;
          3'b100:  entry.op = SLT;
          3'b101:  entry.op = GE;
          3'b110:  entry.op = SLTU;
          3'b111:  entry.op = GEU;
          default: begin
            entry         = '0;
            entry.illegal = 1'b1;
          end
        endcase
      end
      default: entry.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_issue.sv
// Execute-stage issue buffer: decode, then a main + skid register pair so
// in_ready can be registered without losing throughput.
module ex_issue
  import ex_pkg::*;
#(
  parameter bit RESET_READY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  ex_issue_if.slave   bus
);

  issue_entry_t dec;
  issue_entry_t main_q;
  issue_entry_t skid_q;
  logic         main_valid_q;
  logic         skid_valid_q;
  logic         in_ready_q;

  logic         accept;
  logic         main_free;
  logic         main_valid_d;
  logic         skid_valid_d;

  ex_issue_decode u_decode (
    .opcode   (bus.in_opcode),
    .funct3   (bus.in_funct3),
    .funct7_5 (bus.in_funct7_5),
    .pc       (bus.in_pc),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .imm      (bus.in_imm),
    .entry    (dec)
  );

  // in_ready is low whenever the skid holds data, so accept and a pending skid never coincide.
  always_comb begin
    accept       = bus.in_valid & in_ready_q;
    main_free    = ~main_valid_q | bus.out_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (main_free) begin
      main_valid_d = skid_valid_q | accept;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= RESET_READY;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      if (main_free) begin
        if (skid_valid_q)
          main_q <= skid_q;
        else if (accept)
          main_q <= dec;
      end else if (accept) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = main_valid_q;
  assign bus.out_alu_op       = main_q.op;
  assign bus.out_alu_rs1      = main_q.a;
  assign bus.out_alu_rs2      = main_q.b;
  assign bus.out_branch       = main_q.branch;
  assign bus.out_take_on_zero = main_q.take_on_zero;
  assign bus.out_illegal      = main_q.illegal;

endmodule

// File: tb/tb_ex_issue.sv
// Scoreboard bench for ex_issue: directed instructions push hand-computed
// expectations, a negedge monitor pops and compares on each output transfer.
module tb_ex_issue;
  import ex_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  ex_issue_if bus ();

  ex_issue #(.RESET_READY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    issue_entry_t e;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_waits = 0;
  issue_entry_t act;
  issue_entry_t held;
  logic         hold_v  = 1'b0;

  function automatic issue_entry_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                      logic br, logic tz, logic ill);
    issue_entry_t e;
    e.op = op; e.a = a; e.b = b; e.branch = br; e.take_on_zero = tz; e.illegal = ill;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Output monitor: compares each transfer against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      act = mk(bus.out_alu_op, bus.out_alu_rs1, bus.out_alu_rs2,
               bus.out_branch, bus.out_take_on_zero, bus.out_illegal);
      if (hold_v) begin
        n_tests++;
        if (act !== held) begin
          n_fail++;
          $display("FAIL stall_stable: got %h expected %h", act, held);
        end
      end
      if (bus.out_ready) begin
        n_tests++;
        hold_v = 1'b0;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", act);
        end else begin
          exp_t x;
          x = sb.pop_front();
          if (act !== x.e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", x.name, act, x.e);
          end
        end
      end else begin
        hold_v = 1'b1;
        held   = act;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic drive(logic [6:0] opc, logic [2:0] f3, logic f75,
                       logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm);
    bus.in_opcode   = opc;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f75;
    bus.in_pc       = pc;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_valid    = 1'b1;
  endtask

  task automatic send(string name, logic [6:0] opc, logic [2:0] f3, logic f75,
                      logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                      issue_entry_t e);
    int cnt;
    cnt = 0;
    drive(opc, f3, f75, pc, rs1, rs2, imm);
    while (!bus.in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_waits += cnt;
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: got in_ready=0 expected 1 within 100 cycles", name);
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back('{name, e});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(string name);
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.in_valid  = 1'b0;

    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_flags", {28'd0, bus.out_branch, bus.out_take_on_zero, bus.out_illegal, 1'b0}, 32'd0);
    check("rst_op",    {28'd0, bus.out_alu_op}, 32'd0);
    check("rst_a",     bus.out_alu_rs1, 32'd0);
    check("rst_b",     bus.out_alu_rs2, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Single ADDI, output must be visible right after the accepting edge.
    bus.out_ready = 1'b1;
    send("addi", OPC_OP_IMM, 3'b000, 1'b0, 32'h0, 32'd5, 32'd0, 32'hFFFF_FFFD,
         mk(SUM, 32'd5, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0));
    check("addi_latency", {31'd0, bus.out_valid}, 32'd1);
    wait_drain("addi");

    // Back-to-back stream at full rate.
    n_waits = 0;
    send("sra",    OPC_OP,     3'b101, 1'b1, 32'h0, 32'h8000_0000, 32'd4, 32'h0,
         mk(SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 1'b0));
    send("bne",    OPC_BRANCH, 3'b001, 1'b0, 32'h0, 32'd1, 32'd2, 32'h10,
         mk(SUB, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0));
    send("auipc",  OPC_AUIPC,  3'b000, 1'b0, 32'h100, 32'h9, 32'h9, 32'h1000,
         mk(SUM, 32'h100, 32'h1000, 1'b0, 1'b0, 1'b0));
    send("sub",    OPC_OP,     3'b000, 1'b1, 32'h0, 32'd10, 32'd3, 32'h0,
         mk(SUB, 32'd10, 32'd3, 1'b0, 1'b0, 1'b0));
    send("sltiu",  OPC_OP_IMM, 3'b011, 1'b0, 32'h0, 32'd7, 32'd1, 32'd8,
         mk(SLTU, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0));
    send("bgeu",   OPC_BRANCH, 3'b111, 1'b0, 32'h0, 32'd4, 32'd5, 32'h0,
         mk(GEU, 32'd4, 32'd5, 1'b1, 1'b0, 1'b0));
    send("store",  OPC_STORE,  3'b010, 1'b0, 32'h0, 32'h2000, 32'h55, 32'h8,
         mk(SUM, 32'h2000, 32'h8, 1'b0, 1'b0, 1'b0));
    send("srai_f", OPC_OP_IMM, 3'b101, 1'b0, 32'h0, 32'hF0, 32'h0, 32'h2,
         mk(SRL, 32'hF0, 32'h2, 1'b0, 1'b0, 1'b0));
    send("jalr",   OPC_JALR,   3'b000, 1'b0, 32'h44, 32'h1, 32'h2, 32'h3,
         mk(SUM, 32'h44, 32'd4, 1'b0, 1'b0, 1'b0));
    check("throughput_waits", n_waits, 32'd0);
    wait_drain("stream");

    // Stall: two accepted, third waits, outputs hold the first.
    bus.out_ready = 1'b0;
    send("lui", OPC_LUI, 3'b000, 1'b0, 32'h0, 32'd7, 32'd0, 32'hABCD_E000,
         mk(SUM, 32'h0, 32'hABCD_E000, 1'b0, 1'b0, 1'b0));
    send("jal", OPC_JAL, 3'b000, 1'b0, 32'h200, 32'd0, 32'd0, 32'h40,
         mk(SUM, 32'h200, 32'd4, 1'b0, 1'b0, 1'b0));
    check("skid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(OPC_BRANCH, 3'b000, 1'b0, 32'h0, 32'd3, 32'd3, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_b", bus.out_alu_rs2, 32'hABCD_E000);
    end
    bus.out_ready = 1'b1;
    send("beq", OPC_BRANCH, 3'b000, 1'b0, 32'h0, 32'd3, 32'd3, 32'h0,
         mk(SUB, 32'd3, 32'd3, 1'b1, 1'b1, 1'b0));
    wait_drain("stall");

    // Illegal encodings still flow through the handshake.
    send("illegal_opc", 7'b1111111, 3'b101, 1'b1, 32'h40, 32'hFFFF, 32'h1234, 32'h55,
         mk(AND, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    send("illegal_br",  OPC_BRANCH, 3'b010, 1'b0, 32'h40, 32'h1, 32'h2, 32'h3,
         mk(AND, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    wait_drain("illegal");

    // Flush with skid full, then flush with an input offered while ready.
    bus.out_ready = 1'b0;
    send("fl_a", OPC_OP_IMM, 3'b000, 1'b0, 32'h0, 32'd1, 32'd0, 32'd1,
         mk(SUM, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0));
    send("fl_b", OPC_OP_IMM, 3'b000, 1'b0, 32'h0, 32'd2, 32'd0, 32'd2,
         mk(SUM, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0));
    drive(OPC_OP_IMM, 3'b000, 1'b0, 32'h0, 32'hDEAD, 32'd0, 32'd1);
    flush = 1'b1;
    tick(1);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
    tick(1);
    check("flush_drop", {31'd0, bus.out_valid}, 32'd0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    tick(1);
    check("flush_idle", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    send("post_flush", OPC_OP_IMM, 3'b110, 1'b0, 32'h0, 32'h77, 32'd0, 32'h0,
         mk(OR, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0));
    wait_drain("flush");

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    send("rst_victim", OPC_LUI, 3'b000, 1'b0, 32'h0, 32'd0, 32'd0, 32'h1234_5000,
         mk(SUM, 32'h0, 32'h1234_5000, 1'b0, 1'b0, 1'b0));
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_b",     bus.out_alu_rs2, 32'd0);
    check("async_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.delete();
    tick(2);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick(1);
    send("post_rst", OPC_AUIPC, 3'b000, 1'b0, 32'h300, 32'd0, 32'd0, 32'h10,
         mk(SUM, 32'h300, 32'h10, 1'b0, 1'b0, 1'b0));
    wait_drain("post_rst");

    tick(3);
    check("final_pending", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
